// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: 50 MHz rate constants, channel indices and default reset periods
package tick_gen_pkg;
  localparam int unsigned ONE_SECOND = 50_000_000;
  localparam int unsigned BALL_TIME = 12_500_000;
  localparam int unsigned PLATE_TIME = 25_000_000;
  localparam int unsigned REFRESH_TIME = 1_250_000;
  localparam int unsigned DOTMATRIX_TIME = 40_000;
  localparam int unsigned GOAL_TIME = 100_000_000;
  localparam int CH_TIME = 0;
  localparam int CH_BALL = 1;
  localparam int CH_PLATE = 2;
  localparam int CH_REFRESH = 3;
  localparam int CH_DOTMATRIX = 4;
  localparam int CH_GOAL = 5;
  localparam int DEF_NUM_CH = 6;
  localparam int DEF_CNT_W = 32;
  localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_INIT_PERIODS = {6{32'd50_000_000}};
  // index width for a selector over n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: per-channel controls, period write port and tick/done strobes
interface tick_gen_if import tick_gen_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int CH_W = idx_w(NUM_CH);
  logic [NUM_CH-1:0] en, clr, oneshot, tick, done;
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  modport master (output en, clr, oneshot, cfg_we, cfg_ch, cfg_period, input tick, done);
  modport slave (input en, clr, oneshot, cfg_we, cfg_ch, cfg_period, output tick, done);
endinterface

// File: rtl/tick_gen_channel.sv
// tick_gen_channel: one programmable countdown slice producing a registered tick
module tick_gen_channel #(
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] INIT_PERIOD = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic oneshot_i,
  input  logic we_i,
  input  logic [CNT_W-1:0] period_i,
  output logic tick_o,
  output logic done_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_CNT = INIT_PERIOD == '0 ? '0 : INIT_PERIOD - ONE;
  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic tick_q, tick_d, done_q, done_d;
  assign tick_o = tick_q;
  assign done_o = done_q;
  // restart wins, then a zero period or a parked/paused channel holds; otherwise count down and reload on zero
  always_comb begin
    period_d = we_i ? period_i : period_q;
    cnt_d = cnt_q;
    tick_d = 1'b0;
    done_d = done_q;
    if (clr_i) begin
      cnt_d = period_d == '0 ? '0 : period_d - ONE;
      done_d = 1'b0;
    end else if (period_q != '0 && !done_q && en_i && stb_i) begin
      tick_d = cnt_q == '0;
      cnt_d = cnt_q == '0 ? period_q - ONE : cnt_q - ONE;
      done_d = cnt_q == '0 && oneshot_i;
    end
  end
  // channel state, cleared back to the build-time period on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= INIT_PERIOD;
      cnt_q <= INIT_CNT;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q <= cnt_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel enable-strobe generator; TICK_GEN_PRESCALE_EN adds a shared prescaler
module tick_gen import tick_gen_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_PERIODS = DEF_INIT_PERIODS,
  parameter int PRESCALE = 1
) (
  input logic clk,
  input logic rst,
  tick_gen_if.slave bus
);
  localparam int CH_W = idx_w(NUM_CH);
  logic stb;
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tick_gen: PRESCALE must be at least 1");
  end
`ifdef TICK_GEN_PRESCALE_EN
  localparam int PS_W = idx_w(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);
  logic [PS_W-1:0] ps_q, ps_d;
  assign stb = ps_q == PS_LAST;
  // shared prescaler wraps after PRESCALE cycles, strobing on its last count
  always_comb ps_d = stb ? '0 : ps_q + PS_ONE;
  // prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps_q <= '0;
    else ps_q <= ps_d;
  end
`else
  assign stb = 1'b1;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_gen_channel #(
      .CNT_W(CNT_W),
      .INIT_PERIOD(INIT_PERIODS[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .stb_i(stb),
      .en_i(bus.en[i]),
      .clr_i(bus.clr[i]),
      .oneshot_i(bus.oneshot[i]),
      .we_i(bus.cfg_we && bus.cfg_ch == CH_W'(i)),
      .period_i(bus.cfg_period),
      .tick_o(bus.tick[i]),
      .done_o(bus.done[i])
    );
  end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: randomized and directed bench for tick_gen against a strobe-counting model
module tb_tick_gen;
  localparam int N = 6;
  localparam int W = 16;
`ifdef TICK_GEN_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  localparam logic [N*W-1:0] INIT = {16'd2, 16'd6, 16'd5, 16'd3, 16'd1, 16'd4};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  tick_gen_if #(.NUM_CH(N), .CNT_W(W)) bus ();
  tick_gen #(.NUM_CH(N), .CNT_W(W), .INIT_PERIODS(INIT), .PRESCALE(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // model: left[i] = enabled strobes still to go before channel i ticks
  logic [N-1:0] exp_tk, exp_dn;
  int left[N];
  int per_m[N];
  int pc, cyc, m_pn;
  logic m_stb;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      per_m[i] = int'(INIT[i*W +: W]);
      left[i] = per_m[i] == 0 ? 1 : per_m[i];
    end
    exp_tk = '0;
    exp_dn = '0;
    pc = 0;
    cyc = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        m_stb = pc == PS - 1;
        pc = (pc + 1) % PS;
        cyc++;
        for (int i = 0; i < N; i++) begin
          m_pn = (bus.cfg_we && int'(bus.cfg_ch) == i) ? int'(bus.cfg_period) : per_m[i];
          exp_tk[i] = 1'b0;
          if (bus.clr[i]) begin
            left[i] = m_pn == 0 ? 1 : m_pn;
            exp_dn[i] = 1'b0;
          end else if (per_m[i] != 0 && !exp_dn[i] && bus.en[i] && m_stb) begin
            left[i]--;
            if (left[i] == 0) begin
              exp_tk[i] = 1'b1;
              left[i] = per_m[i];
              exp_dn[i] = bus.oneshot[i];
            end
          end
          per_m[i] = m_pn;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checks++;
      if (bus.tick !== exp_tk) begin
        errors++;
        $display("FAIL tick cyc=%0d dut=%b model=%b", cyc, bus.tick, exp_tk);
      end
      checks++;
      if (bus.done !== exp_dn) begin
        errors++;
        $display("FAIL done cyc=%0d dut=%b model=%b", cyc, bus.done, exp_dn);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_tk(input int ch, output int c);
    int n;
    n = 0;
    c = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!exp_tk[ch] && n < 64);
    if (exp_tk[ch]) c = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for tick on ch%0d", ch);
    end
  endtask

  int c, c0, n;
  initial begin
    bus.en = '0;
    bus.clr = '0;
    bus.oneshot = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_period = '0;
    repeat (2) @(negedge clk);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    bus.en = 6'b000011;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("per_ch0", 32'(exp_tk[0]), 32'((k % (4 * PS)) == 0));
      chk("per_ch1", 32'(exp_tk[1]), 32'((k % PS) == 0));
    end
`ifndef TICK_GEN_PRESCALE_EN
    bus.clr[3] = 1'b1;
    bus.en[3] = 1'b1;
    @(negedge clk);
    bus.clr[3] = 1'b0;
    c0 = cyc;
    repeat (2) @(negedge clk);
    bus.en[3] = 1'b0;
    repeat (3) @(negedge clk);
    bus.en[3] = 1'b1;
    wait_tk(3, c);
    chk("pause_at", c, c0 + 8);
    @(negedge clk);
    chk("pause_width", 32'(exp_tk[3]), 0);
    bus.clr[2] = 1'b1;
    bus.oneshot[2] = 1'b1;
    bus.en[2] = 1'b1;
    @(negedge clk);
    bus.clr[2] = 1'b0;
    c0 = cyc;
    wait_tk(2, c);
    chk("os_at", c, c0 + 3);
    chk("os_done", 32'(exp_dn[2]), 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(exp_tk[2]);
    end
    chk("os_quiet", n, 0);
    bus.clr[2] = 1'b1;
    @(negedge clk);
    bus.clr[2] = 1'b0;
    c0 = cyc;
    chk("os_clr_done", 32'(exp_dn[2]), 0);
    wait_tk(2, c);
    chk("os_reclr", c, c0 + 3);
    bus.clr[4] = 1'b1;
    bus.en[4] = 1'b1;
    @(negedge clk);
    bus.clr[4] = 1'b0;
    c0 = cyc;
    repeat (2) @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 3'd4;
    bus.cfg_period = 16'd2;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_tk(4, c);
    chk("wr_old", c, c0 + 6);
    wait_tk(4, c);
    chk("wr_new", c, c0 + 8);
    bus.clr[4] = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_period = 16'd7;
    @(negedge clk);
    c0 = cyc;
    bus.clr[4] = 1'b0;
    bus.cfg_ch = 3'd7;
    bus.cfg_period = 16'd1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_tk(4, c);
    chk("clr_wr", c, c0 + 7);
    wait_tk(4, c);
    chk("bad_ch_ignored", c, c0 + 14);
    bus.en[5] = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 3'd5;
    bus.cfg_period = 16'd0;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(bus.tick[5]);
    end
    chk("p0_quiet", n, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_tick", 32'(bus.tick), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_tk(5, c);
    chk("arst_init_period", c, 2);
`endif
    repeat (3000) begin
      @(negedge clk);
      bus.en = 6'($urandom | $urandom);
      bus.clr = 6'($urandom & $urandom & $urandom & $urandom);
      bus.oneshot = 6'($urandom & $urandom);
      bus.cfg_we = ($urandom % 8) == 0;
      bus.cfg_ch = 3'($urandom);
      bus.cfg_period = 16'($urandom % 10);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
